// File: rtl/core_acc_pkg.sv
// core_acc_pkg: shared widths, state encoding and saturating adder for core_acc
//   ARR_IDATA_BIT / ARR_ODATA_BIT : array widths used when no global header is present
//   IDLE / ACC                    : state encoding of the accumulator window FSM
//   sat_add(a, b, w)              : w-bit signed clamped sum of a+b plus overflow flag
`ifndef ARR_IDATA_BIT
`define ARR_IDATA_BIT 8
`endif
`ifndef ARR_ODATA_BIT
`define ARR_ODATA_BIT 20
`endif

package core_acc_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic ACC  = 1'b1;

    typedef struct packed {
        logic signed [63:0] sum;
        logic               ovf;
    } sat_t;

    // The 64-bit sum never wraps for w <= 62, so it serves as the wide
    // intermediate before clamping into the w-bit signed range.
    function automatic sat_t sat_add(input logic signed [63:0] a,
                                     input logic signed [63:0] b,
                                     input int                 w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               r;
        s     = a + b;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        r.sum = (s > hi) ? hi : ((s < lo) ? lo : s);
        return r;
    endfunction

endpackage

// File: rtl/core_acc.sv
// core_acc: windowed signed accumulator feeding the quantize stage
//   clk, rst      : clock and synchronous active-high reset
//   cfg_acc_num   : beats per window (0 behaves as 1), latched on a window's first beat
//   acc_clear     : abort the open window and clear cnt/acc/acc_ovf
//   idata         : signed product beat, qualified by idata_valid
//   odata         : saturated window sum, held until the next completed window
//   odata_valid   : one-cycle pulse the cycle after a window's last beat
//   acc_busy      : a multi-beat window is open
//   acc_ovf       : sticky saturation flag
module core_acc
    import core_acc_pkg::*;
#(
    parameter int IDATA_BIT = 2 * `ARR_IDATA_BIT,
    parameter int ODATA_BIT = `ARR_ODATA_BIT,
    parameter int ACC_NUM_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ACC_NUM_W-1:0]        cfg_acc_num,
    input  logic                        acc_clear,
    input  logic signed [IDATA_BIT-1:0] idata,
    input  logic                        idata_valid,
    output logic signed [ODATA_BIT-1:0] odata,
    output logic                        odata_valid,
    output logic                        acc_busy,
    output logic                        acc_ovf
);

    logic                        state;
    logic                        state_nxt;
    logic [ACC_NUM_W-1:0]        cnt;
    logic [ACC_NUM_W-1:0]        n_reg;
    logic signed [ODATA_BIT-1:0] acc;
    logic signed [ODATA_BIT-1:0] sum;
    logic                        beat;
    logic                        first;
    logic                        last;
    sat_t                        res;

    // The first beat of a window starts from zero instead of the stale acc,
    // so no separate clear cycle is needed between back-to-back windows.
    // In IDLE the live cfg_acc_num decides; inside a window the latched n_reg does.
    always_comb begin
        beat  = idata_valid & ~acc_clear;
        first = (state == IDLE);
        last  = first ? (cfg_acc_num <= ACC_NUM_W'(1)) : (cnt == n_reg - 1'b1);
        res   = sat_add(first ? 64'sd0 : 64'(acc), 64'(idata), ODATA_BIT);
        sum   = ODATA_BIT'(res.sum);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = acc_clear ? IDLE : (beat ? (last ? IDLE : ACC) : state);
    end

    always_comb begin
        acc_busy = (state == ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            n_reg       <= '0;
            acc         <= '0;
            odata       <= '0;
            odata_valid <= 1'b0;
            acc_ovf     <= 1'b0;
        end else if (acc_clear) begin
            cnt         <= '0;
            acc         <= '0;
            odata_valid <= 1'b0;
            acc_ovf     <= 1'b0;
        end else begin
            odata_valid <= beat & last;
            if (beat) begin
                acc     <= sum;
                acc_ovf <= acc_ovf | res.ovf;
                cnt     <= last ? '0 : cnt + 1'b1;
                if (first)
                    n_reg <= cfg_acc_num;
                if (last)
                    odata <= sum;
            end
        end
    end

endmodule

// File: tb/tb_core_acc.sv
// tb_core_acc: randomized and directed self-checking bench for core_acc
module tb_core_acc;

    localparam int IW = 16;
    localparam int OW = 20;
    localparam int NW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NW-1:0]        cfg_acc_num = 8'd4;
    logic                 acc_clear = 1'b0;
    logic signed [IW-1:0] idata = '0;
    logic                 idata_valid = 1'b0;
    logic signed [OW-1:0] odata;
    logic                 odata_valid;
    logic                 acc_busy;
    logic                 acc_ovf;

    int cmp = 0;
    int err = 0;

    // Reference model: window as a running count of beats and a clamped integer sum.
    longint m_sum = 0;
    longint m_o   = 0;
    int     m_cnt = 0;
    int     m_n   = 1;
    bit     m_v   = 0;
    bit     m_f   = 0;
    bit     m_b   = 0;
    logic [OW-1:0] m_ow;

    core_acc #(.IDATA_BIT(IW), .ODATA_BIT(OW), .ACC_NUM_W(NW)) dut (
        .clk(clk), .rst(rst), .cfg_acc_num(cfg_acc_num), .acc_clear(acc_clear),
        .idata(idata), .idata_valid(idata_valid), .odata(odata),
        .odata_valid(odata_valid), .acc_busy(acc_busy), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick(input bit v, input int d, input bit clr, input bit r);
        longint lim;
        int     c;
        lim         = 64'sd1 <<< (OW - 1);
        c           = int'(cfg_acc_num);
        idata_valid = v;
        idata       = d[IW-1:0];
        acc_clear   = clr;
        rst         = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_sum = 0; m_o = 0; m_cnt = 0; m_v = 0; m_f = 0;
        end else if (clr) begin
            m_sum = 0; m_cnt = 0; m_v = 0; m_f = 0;
        end else begin
            m_v = 0;
            if (v) begin
                if (m_cnt == 0) begin
                    m_n   = (c == 0) ? 1 : c;
                    m_sum = d;
                end else begin
                    m_sum = m_sum + d;
                    if (m_sum > lim - 1) begin
                        m_sum = lim - 1; m_f = 1;
                    end else if (m_sum < -lim) begin
                        m_sum = -lim; m_f = 1;
                    end
                end
                m_cnt++;
                if (m_cnt >= m_n) begin
                    m_v = 1; m_o = m_sum; m_cnt = 0;
                end
            end
        end
        m_b         = (m_cnt != 0);
        m_ow        = m_o[OW-1:0];
        idata_valid = 1'b0;
        acc_clear   = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 1);
        cmp++; if (odata !== '0) begin err++; $display("FAIL reset_odata: got %0d want 0", odata); end
        cmp++; if (odata_valid !== 1'b0) begin err++; $display("FAIL reset_valid: got %b want 0", odata_valid); end
        cmp++; if (acc_busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", acc_busy); end
        cmp++; if (acc_ovf !== 1'b0) begin err++; $display("FAIL reset_ovf: got %b want 0", acc_ovf); end
    endtask

    task automatic test_basic();
        int vals[4] = '{10, -3, 7, 2};
        cfg_acc_num = 8'd4;
        foreach (vals[i]) begin
            tick(1, vals[i], 0, 0);
            cmp++;
            if ({odata_valid, acc_busy, acc_ovf, odata} !== {m_v, m_b, m_f, m_ow}) begin
                err++;
                $display("FAIL basic beat%0d: got v=%b b=%b f=%b o=%0d want v=%b b=%b f=%b o=%0d",
                         i, odata_valid, acc_busy, acc_ovf, odata, m_v, m_b, m_f, $signed(m_ow));
            end
        end
        cmp++; if (odata_valid !== 1'b1 || odata !== 20'sd16 || acc_ovf !== 1'b0) begin
            err++; $display("FAIL basic_result: got v=%b o=%0d f=%b want v=1 o=16 f=0", odata_valid, odata, acc_ovf);
        end
        tick(0, 0, 0, 0);
        cmp++; if (odata_valid !== 1'b0 || odata !== 20'sd16) begin
            err++; $display("FAIL basic_one_pulse: got v=%b o=%0d want v=0 o=16", odata_valid, odata);
        end
    endtask

    task automatic test_gaps();
        cfg_acc_num = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            tick(1, i, 0, 0);
            cmp++;
            if (odata_valid !== (i == 4) || acc_busy !== (i < 4)) begin
                err++; $display("FAIL gaps beat%0d: got v=%b b=%b want v=%b b=%b", i, odata_valid, acc_busy, i == 4, i < 4);
            end
            if (i < 4) begin
                for (int g = 0; g < 2; g++) begin
                    tick(0, 0, 0, 0);
                    cmp++;
                    if ({odata_valid, acc_busy, odata} !== {m_v, m_b, m_ow}) begin
                        err++; $display("FAIL gaps idle%0d: got v=%b b=%b o=%0d want v=%b b=%b o=%0d",
                                        i, odata_valid, acc_busy, odata, m_v, m_b, $signed(m_ow));
                    end
                end
            end
        end
        cmp++; if (odata !== 20'sd10) begin err++; $display("FAIL gaps_result: got %0d want 10", odata); end
    endtask

    task automatic test_back_to_back();
        cfg_acc_num = 8'd2;
        for (int i = 1; i <= 6; i++) begin
            tick(1, i, 0, 0);
            cmp++;
            if (odata_valid !== (i % 2 == 0) || (i % 2 == 0 && odata !== OW'(2 * i - 1))) begin
                err++; $display("FAIL b2b beat%0d: got v=%b o=%0d want v=%b o=%0d", i, odata_valid, odata, i % 2 == 0, 2 * i - 1);
            end
        end
        tick(1, 1, 0, 0);
        cfg_acc_num = 8'd3;
        tick(1, 2, 0, 0);
        cmp++; if (odata_valid !== 1'b1 || odata !== 20'sd3) begin
            err++; $display("FAIL b2b_latch: got v=%b o=%0d want v=1 o=3", odata_valid, odata);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 5, 0, 0);
            cmp++;
            if ({odata_valid, acc_busy, odata} !== {m_v, m_b, m_ow}) begin
                err++; $display("FAIL b2b_n3 beat%0d: got v=%b b=%b o=%0d want v=%b b=%b o=%0d",
                                i, odata_valid, acc_busy, odata, m_v, m_b, $signed(m_ow));
            end
        end
        cmp++; if (odata !== 20'sd15) begin err++; $display("FAIL b2b_n3_result: got %0d want 15", odata); end
    endtask

    task automatic test_saturate();
        cfg_acc_num = 8'd20;
        for (int i = 0; i < 20; i++) tick(1, 32767, 0, 0);
        cmp++; if (odata_valid !== 1'b1 || odata !== 20'sh7FFFF || acc_ovf !== 1'b1) begin
            err++; $display("FAIL sat_pos: got v=%b o=%0d f=%b want v=1 o=524287 f=1", odata_valid, odata, acc_ovf);
        end
        for (int i = 0; i < 20; i++) tick(1, -32768, 0, 0);
        cmp++; if (odata_valid !== 1'b1 || odata !== 20'sh80000 || acc_ovf !== 1'b1) begin
            err++; $display("FAIL sat_neg: got v=%b o=%0d f=%b want v=1 o=-524288 f=1", odata_valid, odata, acc_ovf);
        end
    endtask

    task automatic test_single();
        for (int n = 0; n <= 1; n++) begin
            cfg_acc_num = NW'(n);
            for (int i = 0; i < 3; i++) begin
                tick(1, -5, 0, 0);
                cmp++;
                if (odata_valid !== 1'b1 || odata !== -20'sd5 || acc_busy !== 1'b0) begin
                    err++; $display("FAIL single n%0d beat%0d: got v=%b o=%0d b=%b want v=1 o=-5 b=0", n, i, odata_valid, odata, acc_busy);
                end
            end
        end
    endtask

    task automatic test_clear();
        tick(0, 0, 1, 0);
        cmp++; if (acc_ovf !== 1'b0) begin err++; $display("FAIL clear_ovf: got %b want 0", acc_ovf); end
        cfg_acc_num = 8'd4;
        tick(1, 7, 0, 0);
        tick(1, 7, 0, 0);
        tick(1, 100, 1, 0);
        cmp++; if (odata_valid !== 1'b0 || acc_busy !== 1'b0 || odata !== -20'sd5) begin
            err++; $display("FAIL clear_abort: got v=%b b=%b o=%0d want v=0 b=0 o=-5", odata_valid, acc_busy, odata);
        end
        for (int i = 0; i < 4; i++) tick(1, 1, 0, 0);
        cmp++; if (odata_valid !== 1'b1 || odata !== 20'sd4) begin
            err++; $display("FAIL clear_next: got v=%b o=%0d want v=1 o=4", odata_valid, odata);
        end
    endtask

    task automatic test_rst_mid();
        cfg_acc_num = 8'd4;
        tick(1, 9, 0, 0);
        tick(1, 9, 0, 0);
        tick(1, 9, 0, 1);
        cmp++; if ({odata_valid, acc_busy, acc_ovf, odata} !== 23'd0) begin
            err++; $display("FAIL rst_mid: got v=%b b=%b f=%b o=%0d want all 0", odata_valid, acc_busy, acc_ovf, odata);
        end
        tick(1, 9, 0, 0);
        tick(0, 0, 0, 0);
        cmp++; if (odata_valid !== 1'b0 || acc_busy !== 1'b1) begin
            err++; $display("FAIL rst_mid_after: got v=%b b=%b want v=0 b=1", odata_valid, acc_busy);
        end
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 600; i++) begin
            cfg_acc_num = NW'($urandom_range(0, 24));
            d = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                            : $urandom_range(0, 65535) - 32768;
            tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 59) == 0, 0);
            cmp++;
            if ({odata_valid, acc_busy, acc_ovf, odata} !== {m_v, m_b, m_f, m_ow}) begin
                err++; $display("FAIL random cyc%0d: got v=%b b=%b f=%b o=%0d want v=%b b=%b f=%b o=%0d",
                                i, odata_valid, acc_busy, acc_ovf, odata, m_v, m_b, m_f, $signed(m_ow));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_saturate();
        test_single();
        test_clear();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
